// File: rtl/seg_scan_decoder.sv
// Recovers the two digits shown on a multiplexed 7-segment display bus.
// Optional macro SEG_DP_CAPTURE_EN adds decimal-point capture on the DP output.
module seg_scan_decoder #(
    parameter int SETTLE_CYC   = 4,
    parameter int STABLE_SCANS = 3
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic [1:0] COM,
    input  logic [7:0] SEG,
    output logic [3:0] Digit_Ones,
    output logic [3:0] Digit_Tens,
`ifdef SEG_DP_CAPTURE_EN
    output logic [1:0] DP,
`endif
    output logic       Data_Valid,
    output logic       Update,
    output logic       Seg_Err
);

`ifdef SEG_DP_CAPTURE_EN
    localparam int CW = 5;
`else
    localparam int CW = 4;
`endif
    localparam logic [CW-1:0] BLANK = CW'(15);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;

    // Returns {valid, code}; the decimal point is never part of the lookup.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case ({s, 1'b0})
            8'hFC:   decode = 5'h10;
            8'h60:   decode = 5'h11;
            8'hDA:   decode = 5'h12;
            8'hF2:   decode = 5'h13;
            8'h66:   decode = 5'h14;
            8'hB6:   decode = 5'h15;
            8'hBE:   decode = 5'h16;
            8'hE0:   decode = 5'h17;
            8'hFE:   decode = 5'h18;
            8'hF6:   decode = 5'h19;
            8'h00:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [1:0]             com_s1_q, com_s2_q, com_lat_q, com_lat_d;
    logic [6:0]             seg_s1_q, seg_s2_q;
    logic [3:0]             settle_q, settle_d;
    logic [1:0][CW-1:0]     cand_q, cand_d, dig_q, dig_d;
    logic [1:0][2:0]        stab_q, stab_d;
    logic [1:0]             done_q, done_d;
    logic                   valid_q, valid_d, upd_q, upd_d, err_q, err_d;
    logic                   sel, tgt;
    logic [2:0]             nstab;
    logic [4:0]             dec;
    logic [CW-1:0]          smp;

`ifdef SEG_DP_CAPTURE_EN
    logic dp_s1_q, dp_s2_q;
    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            dp_s1_q <= 1'b0;
            dp_s2_q <= 1'b0;
        end else begin
            dp_s1_q <= SEG[0];
            dp_s2_q <= dp_s1_q;
        end
    end
    assign DP = {dig_q[1][4], dig_q[0][4]};
`else
    logic unused_dp;
    assign unused_dp = SEG[0];
`endif

    always_comb begin
        state_d   = state_q;
        com_lat_d = com_lat_q;
        settle_d  = settle_q;
        cand_d    = cand_q;
        stab_d    = stab_q;
        dig_d     = dig_q;
        done_d    = done_q;
        upd_d     = 1'b0;
        err_d     = 1'b0;
        sel       = (com_s2_q == 2'b01) || (com_s2_q == 2'b10);
        tgt       = com_lat_q[1];
        dec       = decode(seg_s2_q);
        nstab     = 3'd1;
`ifdef SEG_DP_CAPTURE_EN
        smp       = {dp_s2_q, dec[3:0]};
`else
        smp       = dec[3:0];
`endif
        case (state_q)
            IDLE: if (sel) begin
                state_d   = SETTLE;
                settle_d  = 4'd0;
                com_lat_d = com_s2_q;
            end
            SETTLE, HOLD: begin
                if (com_s2_q != com_lat_q) begin
                    if (sel) begin
                        state_d   = SETTLE;
                        settle_d  = 4'd0;
                        com_lat_d = com_s2_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == SETTLE) begin
                    if (settle_q == 4'(SETTLE_CYC - 1)) state_d = SAMPLE;
                    else                                settle_d = settle_q + 4'd1;
                end
            end
            SAMPLE: begin
                state_d = HOLD;
                if (!dec[4]) begin
                    err_d       = 1'b1;
                    stab_d[tgt] = 3'd0;
                end else begin
                    if (smp == cand_q[tgt])
                        nstab = (stab_q[tgt] == 3'd7) ? 3'd7 : stab_q[tgt] + 3'd1;
                    cand_d[tgt] = smp;
                    stab_d[tgt] = nstab;
                    if (nstab >= 3'(STABLE_SCANS)) begin
                        dig_d[tgt]  = smp;
                        done_d[tgt] = 1'b1;
                        upd_d       = !done_q[tgt] || (dig_q[tgt] != smp);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = valid_q || (done_d == 2'b11);
    end

    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            state_q   <= IDLE;
            com_s1_q  <= 2'b00;
            com_s2_q  <= 2'b00;
            seg_s1_q  <= 7'd0;
            seg_s2_q  <= 7'd0;
            com_lat_q <= 2'b00;
            settle_q  <= 4'd0;
            cand_q    <= {BLANK, BLANK};
            stab_q    <= '0;
            dig_q     <= {BLANK, BLANK};
            done_q    <= 2'b00;
            valid_q   <= 1'b0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            com_s1_q  <= COM;
            com_s2_q  <= com_s1_q;
            seg_s1_q  <= SEG[7:1];
            seg_s2_q  <= seg_s1_q;
            com_lat_q <= com_lat_d;
            settle_q  <= settle_d;
            cand_q    <= cand_d;
            stab_q    <= stab_d;
            dig_q     <= dig_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            err_q     <= err_d;
        end
    end

    assign Digit_Ones = dig_q[0][3:0];
    assign Digit_Tens = dig_q[1][3:0];
    assign Data_Valid = valid_q;
    assign Update     = upd_q;
    assign Seg_Err    = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans the display bus phase by phase and
// checks committed digits and pulse counts against hand-computed values.
module tb_seg_scan_decoder;
    logic       Sys_CLK = 1'b0;
    logic       Sys_RST = 1'b0;
    logic [1:0] COM = 2'b00;
    logic [7:0] SEG = 8'h00;
    logic [3:0] Digit_Ones, Digit_Tens;
    logic       Data_Valid, Update, Seg_Err;
`ifdef SEG_DP_CAPTURE_EN
    logic [1:0] DP;
`endif
    int checks = 0, errors = 0;
    int upd_cnt = 0, err_cnt = 0, both_cnt = 0;
    int u0, e0;

    seg_scan_decoder dut (
        .Sys_CLK(Sys_CLK), .Sys_RST(Sys_RST), .COM(COM), .SEG(SEG),
        .Digit_Ones(Digit_Ones), .Digit_Tens(Digit_Tens),
`ifdef SEG_DP_CAPTURE_EN
        .DP(DP),
`endif
        .Data_Valid(Data_Valid), .Update(Update), .Seg_Err(Seg_Err)
    );

    always #5 Sys_CLK = ~Sys_CLK;

    always @(negedge Sys_CLK) begin
        if (Update === 1'b1) upd_cnt++;
        if (Seg_Err === 1'b1) err_cnt++;
        if (Update === 1'b1 && Seg_Err === 1'b1) both_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Sys_CLK);
        #1;
    endtask

    task automatic phase(input logic [1:0] c, input logic [7:0] s);
        COM = c;
        SEG = s;
        tick(20);
    endtask

    task automatic scan(input logic [7:0] ones, input logic [7:0] tens, input int n);
        for (int i = 0; i < n; i++) begin
            phase(2'b01, ones);
            phase(2'b10, tens);
        end
    endtask

    initial begin
        tick(3);
        chk("rst_ones", Digit_Ones, 15);
        chk("rst_tens", Digit_Tens, 15);
        chk("rst_valid", Data_Valid, 0);
        chk("rst_update", Update, 0);
        chk("rst_err", Seg_Err, 0);
        Sys_RST = 1'b1;
        tick(2);

        // 35 acquired over three scans
        u0 = upd_cnt;
        scan(8'hB6, 8'hF2, 2);
        chk("acq2_valid", Data_Valid, 0);
        chk("acq2_ones", Digit_Ones, 15);
        chk("acq2_upd", upd_cnt - u0, 0);
        phase(2'b01, 8'hB6);
        chk("acq3_ones", Digit_Ones, 5);
        chk("acq3_valid_pre", Data_Valid, 0);
        chk("acq3_upd_ones", upd_cnt - u0, 1);
        phase(2'b10, 8'hF2);
        chk("acq3_tens", Digit_Tens, 3);
        chk("acq3_valid", Data_Valid, 1);
        chk("acq3_upd", upd_cnt - u0, 2);

        // two-scan glitch to 8 never commits
        u0 = upd_cnt;
        scan(8'hFE, 8'hF2, 2);
        scan(8'hB6, 8'hF2, 3);
        chk("glitch_ones", Digit_Ones, 5);
        chk("glitch_tens", Digit_Tens, 3);
        chk("glitch_upd", upd_cnt - u0, 0);

        // undecodable pattern, then a real change to 1
        u0 = upd_cnt; e0 = err_cnt;
        scan(8'h12, 8'hF2, 1);
        chk("bad_err", err_cnt - e0, 1);
        chk("bad_ones", Digit_Ones, 5);
        chk("bad_upd", upd_cnt - u0, 0);
        scan(8'h60, 8'hF2, 3);
        chk("one_ones", Digit_Ones, 1);
        chk("one_upd", upd_cnt - u0, 1);
        chk("one_err", err_cnt - e0, 1);
        scan(8'hB6, 8'hF2, 3);
        chk("back5_ones", Digit_Ones, 5);

        // COM toggling faster than the settle window
        u0 = upd_cnt; e0 = err_cnt;
        SEG = 8'h12;
        for (int i = 0; i < 12; i++) begin
            COM = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick(3);
        end
        COM = 2'b00;
        tick(10);
        chk("fast_upd", upd_cnt - u0, 0);
        chk("fast_err", err_cnt - e0, 0);
        chk("fast_ones", Digit_Ones, 5);
        chk("fast_tens", Digit_Tens, 3);

        // reset in the middle of a settle
        SEG = 8'hB6;
        COM = 2'b01;
        tick(4);
        Sys_RST = 1'b0;
        #1;
        chk("midrst_ones", Digit_Ones, 15);
        chk("midrst_tens", Digit_Tens, 15);
        chk("midrst_valid", Data_Valid, 0);
        tick(2);
        Sys_RST = 1'b1;
        u0 = upd_cnt; e0 = err_cnt;
        tick(5);
        chk("postrst_upd_early", upd_cnt - u0, 0);
        chk("postrst_err_early", err_cnt - e0, 0);
        tick(15);
        chk("postrst_upd", upd_cnt - u0, 0);
        chk("postrst_valid", Data_Valid, 0);

        phase(2'b10, 8'hF2);
        scan(8'hB6, 8'hF2, 2);
        chk("reacq_ones", Digit_Ones, 5);
        chk("reacq_tens", Digit_Tens, 3);
        chk("reacq_valid", Data_Valid, 1);

        // decimal point on the ones digit
        u0 = upd_cnt;
        scan(8'hB7, 8'hF2, 3);
        chk("dp_ones", Digit_Ones, 5);
`ifdef SEG_DP_CAPTURE_EN
        chk("dp_val", DP, 1);
        chk("dp_upd", upd_cnt - u0, 1);
`else
        chk("dp_ignored_upd", upd_cnt - u0, 0);
`endif
        chk("no_coincident_pulses", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
